// File: rtl/stack_drain_rd.sv
// rtl/stack_drain_rd.sv - LIFO drain engine: pops the stack into a 2-entry valid/ready output buffer.
// Optional statistics outputs (pop_total, err_cnt) are enabled by defining STACK_DRAIN_STATS_EN.
module stack_drain_rd #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  stk_pop,
    input  logic                  stk_empty,
    input  logic [DATA_WIDTH-1:0] stk_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef STACK_DRAIN_STATS_EN
    output logic [ADDR_WIDTH:0]   pop_total,
    output logic [7:0]            err_cnt,
`endif
    output logic                  m_last
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         rem_q, rem_d;
    logic                  until_q, until_d;
    logic                  err_q, err_d;
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic                  buf_last_q [2];
    logic                  buf_last_d [2];
    logic                  pop_accept;
    logic                  last_in;

    assign stk_pop    = (state_q == S_DRAIN) && !stk_empty && (occ_q != 2'd2)
                        && (until_q || (rem_q != '0));
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf_data_q[head_q];
    assign m_last     = m_valid && buf_last_q[head_q];
    assign busy       = (state_q != S_IDLE);
    assign pop_accept = m_valid && m_ready;
    // Only the pop that exhausts a counted drain tags its word as last.
    assign last_in    = !until_q && (rem_q == CW'(1));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        until_d    = until_q;
        err_d      = err_q;
        head_d     = head_q;
        tail_d     = tail_q;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = count;
                    until_d = (count == '0);
                    err_d   = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stk_pop) begin
                    if (!until_q) begin
                        rem_d = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            state_d = S_FLUSH;
                        end
                    end
                end else if (stk_empty) begin
                    state_d = S_FLUSH;
                    if (!until_q && (rem_q != '0)) begin
                        err_d = 1'b1;
                    end
                end else if (!until_q && (rem_q == '0)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (occ_q == 2'd0) begin
                    done    = 1'b1;
                    err     = err_q;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stk_pop) begin
            buf_data_d[tail_q] = stk_rd_data;
            buf_last_d[tail_q] = last_in;
            tail_d             = !tail_q;
        end
        if (pop_accept) begin
            head_d = !head_q;
        end
        occ_d = occ_q + (stk_pop ? 2'd1 : 2'd0) - (pop_accept ? 2'd1 : 2'd0);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            until_q    <= 1'b0;
            err_q      <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_data_q <= '{default: '0};
            buf_last_q <= '{default: 1'b0};
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            until_q    <= until_d;
            err_q      <= err_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
        end
    end

`ifdef STACK_DRAIN_STATS_EN
    localparam logic [CW-1:0] MAX_POPS = CW'(1) << ADDR_WIDTH;

    logic [CW-1:0] pop_total_q, pop_total_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    always_comb begin
        pop_total_d = pop_total_q;
        err_cnt_d   = err_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            pop_total_d = '0;
        end else if (stk_pop && (pop_total_q != MAX_POPS)) begin
            pop_total_d = pop_total_q + CW'(1);
        end
        if (err && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pop_total_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            pop_total_q <= pop_total_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pop_total = pop_total_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_stack_drain_rd.sv
// tb/tb_stack_drain_rd.sv - randomized self-checking bench for stack_drain_rd with a behavioural stack.
module tb_stack_drain_rd;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          busy, done, err, stk_pop, stk_empty, m_valid, m_last, m_ready;
    logic [DW-1:0] stk_rd_data, m_data;
    logic          ready_drv = 1'b0;
    logic          rand_ready = 1'b0;
    logic          rnd_ready = 1'b0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;

    logic [DW-1:0] stk_mem [0:31];
    logic [AW:0]   sp = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_stack [$];
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    logic          exp_err;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            hs_cyc [$];
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          done_err = 1'b0;
    int            stray_err = 0;
    int            pop_cnt = 0;
    int            underflow = 0;

    stack_drain_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .count(count),
        .busy(busy), .done(done), .err(err), .stk_pop(stk_pop),
        .stk_empty(stk_empty), .stk_rd_data(stk_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    assign m_ready     = rand_ready ? rnd_ready : ready_drv;
    assign stk_empty   = (sp == '0);
    assign stk_rd_data = (sp == '0) ? '0 : stk_mem[sp - 5'd1];

    // Environment stack: bench pushes, DUT pops; the pointer survives a DUT reset.
    always @(posedge clk) begin
        if (push_en) begin
            stk_mem[sp] <= push_data;
            sp          <= sp + 5'd1;
        end else if (stk_pop) begin
            sp <= sp - 5'd1;
        end
    end

    always @(posedge clk) begin
        #1 rnd_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        cyc++;
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            hs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_err = err;
            done_cyc = cyc;
        end
        if (err && !done) stray_err++;
        if (stk_pop) pop_cnt++;
        if (stk_pop && stk_empty) underflow++;
    end

    task automatic push_word(input logic [DW-1:0] d);
        @(posedge clk); #1;
        push_en   = 1'b1;
        push_data = d;
        exp_stack.push_back(d);
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) push_word(DW'($urandom));
    endtask

    // Reference: a counted drain takes min(count, depth) words from the top,
    // tags the final one last only if the count was satisfied, errs otherwise.
    task automatic begin_drain(input int cnt);
        int n;
        int take;
        n = exp_stack.size();
        take = (cnt == 0) ? n : ((cnt < n) ? cnt : n);
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < take; i++) begin
            exp_data.push_back(exp_stack.pop_back());
            exp_last.push_back((cnt != 0) && (cnt <= n) && (i == take - 1));
        end
        exp_err = (cnt != 0) && (cnt > n);
        got_data.delete();
        got_last.delete();
        hs_cyc.delete();
        done_cnt  = 0;
        stray_err = 0;
        pop_cnt   = 0;
        underflow = 0;
        @(posedge clk); #1;
        start = 1'b1;
        count = (AW+1)'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_drain(input string name, input bit consec);
        int t = 0;
        bit ok;
        while (done_cnt == 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_count got=%0d exp=1", name, done_cnt);
        end
        checks++;
        if (done_err !== exp_err) begin
            errors++;
            $display("FAIL %s err got=%0b exp=%0b", name, done_err, exp_err);
        end
        checks++;
        if (got_data.size() !== exp_data.size()) begin
            errors++;
            $display("FAIL %s word_count got=%0d exp=%0d", name, got_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL %s word%0d got=%h/%0b exp=%h/%0b", name, i,
                             got_data[i], got_last[i], exp_data[i], exp_last[i]);
                end
            end
        end
        checks++;
        if (underflow !== 0 || stray_err !== 0) begin
            errors++;
            $display("FAIL %s pop_on_empty/stray_err got=%0d/%0d exp=0/0", name, underflow, stray_err);
        end
        checks++;
        if (stk_empty !== (exp_stack.size() == 0)) begin
            errors++;
            $display("FAIL %s stk_empty got=%0b exp=%0b", name, stk_empty, exp_stack.size() == 0);
        end
        if (got_data.size() > 0) begin
            checks++;
            if (done_cyc !== hs_cyc[hs_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL %s done_latency got=%0d exp=%0d", name, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
            end
        end
        if (consec && got_data.size() > 1) begin
            ok = 1'b1;
            for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] != hs_cyc[i-1] + 1) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s throughput got=gaps exp=one_word_per_cycle", name);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, err, stk_pop, m_valid, m_last, m_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%b exp=0", {busy, done, err, stk_pop, m_valid, m_last, m_data});
        end
    endtask

    task automatic test_counted;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        ready_drv = 1'b1;
        begin_drain(3);
        finish_drain("counted", 1'b1);
    endtask

    task automatic test_until_empty;
        preload(DEPTH);
        ready_drv = 1'b1;
        begin_drain(0);
        finish_drain("until_empty", 1'b1);
    endtask

    task automatic test_early_empty;
        preload(2);
        ready_drv = 1'b1;
        begin_drain(5);
        finish_drain("early_empty", 1'b0);
    endtask

    task automatic test_full_count;
        preload(DEPTH);
        ready_drv = 1'b1;
        begin_drain(DEPTH);
        finish_drain("full_count", 1'b1);
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] held;
        bit            have = 1'b0;
        bit            stable = 1'b1;
        preload(4);
        ready_drv = 1'b0;
        begin_drain(4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_valid) begin
                if (!have) begin
                    held = m_data;
                    have = 1'b1;
                end else if (m_data !== held) stable = 1'b0;
            end
        end
        checks++;
        if (pop_cnt !== 2) begin
            errors++;
            $display("FAIL backpressure pops got=%0d exp=2", pop_cnt);
        end
        checks++;
        if (!have || !stable || busy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure hold got=valid%0b/stable%0b/busy%0b exp=1/1/1", have, stable, busy);
        end
        ready_drv = 1'b1;
        finish_drain("backpressure", 1'b1);
    endtask

    task automatic test_random;
        int n;
        int c;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, DEPTH - exp_stack.size());
            preload(n);
            c = (it == 4) ? 0 : $urandom_range(0, DEPTH);
            rand_ready = 1'b1;
            begin_drain(c);
            finish_drain($sformatf("random%0d", it), 1'b0);
            rand_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        preload(4);
        ready_drv = 1'b0;
        begin_drain(4);
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, stk_pop, m_valid, m_last, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b exp=0", {busy, done, err, stk_pop, m_valid, m_last, m_data});
        end
        for (int i = exp_data.size() - 1; i >= pop_cnt; i--) exp_stack.push_back(exp_data[i]);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle got=busy%0b/valid%0b exp=0/0", busy, m_valid);
        end
    endtask

    task automatic test_ignored_start;
        preload(3);
        ready_drv = 1'b0;
        begin_drain(2);
        @(posedge clk); #1;
        start = 1'b1;
        count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start busy got=%0b exp=1", busy);
        end
        ready_drv = 1'b1;
        finish_drain("ignored_start", 1'b0);
        begin_drain(0);
        finish_drain("cleanup", 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        test_counted();
        test_until_empty();
        test_early_empty();
        test_full_count();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_drain_rd.md
Name: stack_drain_rd

Overview:
- Read-side engine for the LIFO stack. Given a start command, it issues pop requests to the stack controller and captures the top-of-stack word from the register file's asynchronous read port.
- Popped words leave on a valid/ready stream through a 2-entry output buffer, so the block sustains one word per cycle.
- It sits between the stack controller/register file pair and any downstream consumer.

Parameters:
- DATA_WIDTH, 8, width of one stack word.
- ADDR_WIDTH, 4, stack address width; stack depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle drain command; sampled only in IDLE.
- count  in  ADDR_WIDTH+1  words to pop, sampled with start; 0 means drain until empty.
- busy  out  1  high in DRAIN and FLUSH.
- done  out  1  one-cycle pulse when a drain completes.
- err  out  1  one-cycle pulse with done when the stack ran empty before count was reached.
- stk_pop  out  1  pop request to the stack controller (combinational).
- stk_empty  in  1  stack empty flag.
- stk_rd_data  in  DATA_WIDTH  top-of-stack data, valid in the same cycle whenever stk_empty=0.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks the final word of a counted drain.

Behaviour:
- Reset (arst_n=0, asynchronous) sets:
  - FSM = IDLE, buffer occupancy = 0, remaining counter = 0.
  - busy, done, err, stk_pop, m_valid and m_last all 0; m_data = 0.
- Reset mid-drain discards buffered words. Words already popped are lost, and the stack pointer is not restored.
- FSM states:
  - IDLE: wait for start. On start=1, load remaining=count and mode (count==0 means until-empty), then go to DRAIN. start in any other state is ignored.
  - DRAIN: drive stk_pop = !stk_empty && occ<2 && (mode_until_empty || remaining!=0).
  - FLUSH: no pops. Wait until occ==0, then pulse done (plus err if latched) in the cycle of transition to IDLE.
- Leaving DRAIN for FLUSH:
  - Counted mode, normal end: remaining reaches 0 on the edge of the final pop.
  - Counted mode, early empty: stk_empty=1 while remaining!=0. Latch err.
  - Until-empty mode: stk_empty=1.
- Pop/capture timing:
  - On a clock edge with stk_pop=1, stk_rd_data is written into the buffer tail.
  - Latency from pop to m_valid is exactly 1 cycle. The word is held until accepted.
- Remaining counter: decrements by 1 per pop in counted mode and never wraps below 0.
- Output buffer:
  - 2 entries, in-order (FIFO order of pops, i.e. LIFO order of the stack).
  - A push and a pop of the buffer in the same cycle leaves occupancy unchanged.
  - m_valid = occ!=0. Head advances on m_valid && m_ready.
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
- m_last:
  - Set on the buffer entry captured by the pop that takes remaining from 1 to 0.
  - Never set in until-empty mode or on an err drain.
- Throughput: with m_ready held high, steady state is one pop and one output per cycle at occ=1.
- Concurrent writer pushes during DRAIN are legal. The newly pushed word is popped next, per LIFO order, and counts toward remaining.
- stk_pop is never asserted while stk_empty=1, so the controller never underflows.
- Maximum count: count=2**ADDR_WIDTH is legal and covers a full stack.

Optional Feature:
- Macro: STACK_DRAIN_STATS_EN.
- When defined:
  - Adds output pop_total [ADDR_WIDTH:0], the number of pops in the current or most recent drain.
  - pop_total clears on start and saturates at 2**ADDR_WIDTH.
  - Adds output err_cnt [7:0], which increments on each err pulse, saturates at 255, and is reset by arst_n only.
- When undefined: neither port exists, and there is no extra logic.

Test Plan:
- Counted drain: push 0x11,0x22,0x33; start with count=3 and m_ready=1.
  - m_data sequence is 0x33,0x22,0x11 on consecutive cycles, with m_last on 0x11.
  - done pulses 1 cycle after the last handshake, err=0, stk_empty=1.
- Until-empty drain: preload 16 words; start with count=0.
  - All 16 words emerge in reverse push order, and stk_pop deasserts once stk_empty=1.
  - m_last=0 throughout; done=1 and err=0.
- Early empty: preload 2 words; start with count=5.
  - Exactly 2 words are output.
  - done and err pulse together, and stk_pop is never high while stk_empty=1.
- Backpressure: preload 4 words, count=4, m_ready=0 for 10 cycles.
  - Exactly 2 pops occur, m_data holds steady, busy=1.
  - When m_ready=1 is released, the remaining words drain at 1 per cycle with no loss or duplication.
- Reset and ignored start: assert arst_n=0 mid-drain with occ=2.
  - All outputs go to 0 immediately; after release, FSM=IDLE.
  - A start asserted while busy=1 in a subsequent drain changes neither count nor state.
